// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: size/sign codes, FSM encoding and lane geometry.
package mem_access_unit_pkg;

  localparam int MAU_NB_WIDTH = 32;
  localparam int MAU_NB_DATA  = 8;
  localparam int MAU_NB_LANES = MAU_NB_WIDTH / MAU_NB_DATA;

  localparam logic [2:0] BHW_B    = 3'b000;
  localparam logic [2:0] BHW_H    = 3'b001;
  localparam logic [2:0] BHW_W    = 3'b011;
  localparam logic [2:0] BHW_BU   = 3'b100;
  localparam logic [2:0] BHW_HU   = 3'b101;
  localparam logic [2:0] BHW_WU   = 3'b111;
  localparam logic [2:0] BHW_ILL0 = 3'b010;
  localparam logic [2:0] BHW_ILL1 = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Unused codes are illegal, and a store has no notion of zero-extension.
  function automatic logic bhw_is_illegal(input logic [2:0] bhw, input logic is_store);
    return (bhw == BHW_ILL0) || (bhw == BHW_ILL1) || (is_store && bhw[2]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between a pipeline stage (master) and the memory access unit (slave).
interface mem_access_unit_if #(
  parameter int NB_WIDTH = 32
);
  logic                i_valid;
  logic                o_ready;
  logic                i_mem_read_CU;
  logic                i_mem_write_CU;
  logic [2:0]          i_BHW_CU;
  logic [NB_WIDTH-1:0] i_mem_addr;
  logic [NB_WIDTH-1:0] i_mem_data;
  logic [NB_WIDTH-1:0] o_read_data;
  logic                o_done;
  logic                o_stall;
  logic                o_error;

  modport master (
    output i_valid, i_mem_read_CU, i_mem_write_CU, i_BHW_CU, i_mem_addr, i_mem_data,
    input  o_ready, o_read_data, o_done, o_stall, o_error
  );

  modport slave (
    input  i_valid, i_mem_read_CU, i_mem_write_CU, i_BHW_CU, i_mem_addr, i_mem_data,
    output o_ready, o_read_data, o_done, o_stall, o_error
  );
endinterface

// File: rtl/mem_access_unit_ram.sv
// Word-organised data memory with per-lane write enables, synchronous write and asynchronous read.
module ram_byte_en_single_port
  import mem_access_unit_pkg::*;
#(
  parameter int NB_DATA  = MAU_NB_DATA,
  parameter int NB_LANES = MAU_NB_LANES,
  parameter int NB_WADDR = 8
) (
  input  logic                        i_clk,
  input  logic [NB_LANES-1:0]         i_we,
  input  logic [NB_WADDR-1:0]         i_addr,
  input  logic [NB_LANES*NB_DATA-1:0] i_wdata,
  output logic [NB_LANES*NB_DATA-1:0] o_rdata
);
  logic [NB_LANES*NB_DATA-1:0] mem_q [2**NB_WADDR];

  // Lane-granular write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < NB_LANES; l++) begin
      if (i_we[l]) begin
        mem_q[i_addr][l*NB_DATA +: NB_DATA] <= i_wdata[l*NB_DATA +: NB_DATA];
      end
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: registers one request, waits WAIT_CYCLES, then commits a store or returns an
// extended load; misaligned/illegal requests run full latency and report o_error with o_done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int NB_WIDTH    = MAU_NB_WIDTH,
  parameter int NB_ADDR     = 10,
  parameter int NB_DATA     = MAU_NB_DATA,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  mem_access_unit_if.slave bus
);
  localparam int NB_LANES  = NB_WIDTH / NB_DATA;
  localparam int LANE_BITS = $clog2(NB_LANES);
  localparam int NB_WADDR  = NB_ADDR - LANE_BITS;
  localparam logic [NB_LANES-1:0] LANE_ONE  = {{(NB_LANES-1){1'b0}}, 1'b1};
  localparam logic [NB_LANES-1:0] LANE_PAIR = {{(NB_LANES-2){1'b0}}, 2'b11};

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_WIDTH-1:0] data_q, data_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [2:0]          bhw_q, bhw_d;
  logic [NB_WIDTH-1:0] rdata_q, rdata_d;
  logic                done_q, done_d, error_q, error_d;

  logic                  accept_s, finish_s, misalign_s, req_err_s, unused_addr_s;
  logic [LANE_BITS-1:0]  lane_s, half_base_s;
  logic [NB_LANES-1:0]   be_s, we_s;
  logic [NB_WIDTH-1:0]   wdata_s, rword_s, load_s;
  logic [NB_DATA-1:0]    rd_byte_s;
  logic [2*NB_DATA-1:0]  rd_half_s;

  // Any command bit qualifies a request; read+write together is accepted and flagged later.
  assign accept_s      = (state_q == ST_IDLE) && bus.i_valid && (bus.i_mem_read_CU || bus.i_mem_write_CU);
  assign finish_s      = (state_q == ST_ACCESS) && (cnt_q <= 4'd1);
  assign unused_addr_s = ^bus.i_mem_addr[NB_WIDTH-1:NB_ADDR];

  // Next-state and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    bhw_d   = bhw_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = bus.i_mem_addr[NB_ADDR-1:0];
          data_d  = bus.i_mem_data;
          rd_d    = bus.i_mem_read_CU;
          wr_d    = bus.i_mem_write_CU;
          bhw_d   = bus.i_BHW_CU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (finish_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Lane selection, byte enables, store placement and load extension for the held request.
  always_comb begin
    lane_s      = addr_q[LANE_BITS-1:0];
    half_base_s = {lane_s[LANE_BITS-1:1], 1'b0};
    rd_byte_s   = rword_s[int'(lane_s)*NB_DATA +: NB_DATA];
    rd_half_s   = rword_s[int'(half_base_s)*NB_DATA +: 2*NB_DATA];
    case (bhw_q)
      BHW_B, BHW_BU: begin
        misalign_s = 1'b0;
        be_s       = LANE_ONE << lane_s;
        wdata_s    = {NB_LANES{data_q[NB_DATA-1:0]}};
        load_s     = {{(NB_WIDTH-NB_DATA){rd_byte_s[NB_DATA-1] & ~bhw_q[2]}}, rd_byte_s};
      end
      BHW_H, BHW_HU: begin
        misalign_s = addr_q[0];
        be_s       = LANE_PAIR << half_base_s;
        wdata_s    = {(NB_LANES/2){data_q[2*NB_DATA-1:0]}};
        load_s     = {{(NB_WIDTH-2*NB_DATA){rd_half_s[2*NB_DATA-1] & ~bhw_q[2]}}, rd_half_s};
      end
      BHW_W, BHW_WU: begin
        misalign_s = |lane_s;
        be_s       = {NB_LANES{1'b1}};
        wdata_s    = data_q;
        load_s     = rword_s;
      end
      default: begin
        misalign_s = 1'b0;
        be_s       = {NB_LANES{1'b0}};
        wdata_s    = data_q;
        load_s     = {NB_WIDTH{1'b0}};
      end
    endcase
    req_err_s = misalign_s || bhw_is_illegal(bhw_q, wr_q) || (rd_q && wr_q);
  end

  // Completion: pulse done/error, update load result, commit store unless reset is active.
  always_comb begin
    done_d  = 1'b0;
    error_d = 1'b0;
    rdata_d = rdata_q;
    we_s    = {NB_LANES{1'b0}};
    if (finish_s) begin
      done_d  = 1'b1;
      error_d = req_err_s;
      if (req_err_s) begin
        rdata_d = {NB_WIDTH{1'b0}};
      end else if (wr_q) begin
        we_s = i_reset ? be_s : {NB_LANES{1'b0}};
      end else begin
        rdata_d = load_s;
      end
    end else begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {NB_ADDR{1'b0}};
      data_q  <= {NB_WIDTH{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bhw_q   <= 3'b000;
      rdata_q <= {NB_WIDTH{1'b0}};
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bhw_q   <= bhw_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.o_ready     = (state_q == ST_IDLE);
  assign bus.o_stall     = (state_q != ST_IDLE);
  assign bus.o_read_data = rdata_q;
  assign bus.o_done      = done_q;
  assign bus.o_error     = error_q;

  ram_byte_en_single_port #(
    .NB_DATA  (NB_DATA),
    .NB_LANES (NB_LANES),
    .NB_WADDR (NB_WADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we_s),
    .i_addr  (addr_q[NB_ADDR-1:LANE_BITS]),
    .i_wdata (wdata_s),
    .o_rdata (rword_s)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/back-to-back sequences, random stress vs byte-array model.
module tb_mem_access_unit;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.NB_WIDTH(32)) bus();

  mem_access_unit #(
    .NB_WIDTH(32), .NB_ADDR(10), .NB_DATA(8), .WAIT_CYCLES(W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  code;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  mem_m [1024];
  logic [31:0] hold_m;

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic rd, input logic wr, input logic [2:0] code, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err,
                         input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.code = code; v.addr = addr; v.data = data;
    v.exp_data = exp_data; v.exp_err = exp_err; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    bus.i_valid = 1'b0; bus.i_mem_read_CU = 1'b0; bus.i_mem_write_CU = 1'b0;
    bus.i_BHW_CU = 3'b000; bus.i_mem_addr = 32'h0; bus.i_mem_data = 32'h0;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] code,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.i_valid = 1'b1; bus.i_mem_read_CU = rd; bus.i_mem_write_CU = wr;
    bus.i_BHW_CU = code; bus.i_mem_addr = addr; bus.i_mem_data = data;
  endtask

  // Byte-addressed little-endian memory; result register cleared on error, updated on good loads.
  task automatic model_step(input logic rd, input logic wr, input logic [2:0] code, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] exp_d, output logic exp_e);
    int a, size;
    logic [31:0] v;
    a    = int'(addr % 32'd1024);
    size = (code[1:0] == 2'b00) ? 1 : (code[1:0] == 2'b01) ? 2 : 4;
    exp_e = (rd && wr) || code == 3'b010 || code == 3'b110 || (wr && code[2]) || (a % size != 0);
    if (exp_e) begin
      hold_m = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mem_m[a + i] = data[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
      if (!code[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      hold_m = v;
    end
    exp_d = hold_m;
  endtask

  // Issue one request, scribble random inputs while busy, and time the completion.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] code, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] got_d, output logic got_e);
    int lat, guard;
    bit seen, busy_ok;
    got_d = 32'h0; got_e = 1'b0;
    @(negedge clk);
    check32("done_one_cycle", 32'(bus.o_done), 32'd0);
    guard = 0;
    while (bus.o_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check32("ready_before_req", 32'(bus.o_ready), 32'd1);
    drive_req(rd, wr, code, addr, data);
    @(posedge clk);
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.o_done === 1'b1) begin
        seen = 1; got_d = bus.o_read_data; got_e = bus.o_error;
      end else begin
        if (bus.o_stall !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_error !== 1'b0) busy_ok = 0;
        drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom);
        bus.i_valid = 1'($urandom_range(0, 1));
      end
    end
    drive_idle();
    check32("latency", 32'(lat), 32'(W + 1));
    check32("busy_outputs", 32'(busy_ok), 32'd1);
  endtask

  task automatic run_model_req(input logic rd, input logic wr, input logic [2:0] code, input logic [31:0] addr,
                               input logic [31:0] data, input string nm);
    logic [31:0] ed, gd;
    logic ee, ge;
    model_step(rd, wr, code, addr, data, ed, ee);
    do_req(rd, wr, code, addr, data, gd, ge);
    check32({nm, "_data"}, gd, ed);
    check32({nm, "_err"}, 32'(ge), 32'(ee));
  endtask

  // Reset k negedges after accepting SW 0x12345678 @0x020; k == W lands on the commit edge.
  task automatic reset_during(input int k, input string nm);
    @(negedge clk);
    check32({nm, "_ready_pre"}, 32'(bus.o_ready), 32'd1);
    drive_req(1'b0, 1'b1, 3'b011, 32'h020, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    for (int i = 1; i < k; i++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    hold_m = 32'h0;
    check32({nm, "_rdata"}, bus.o_read_data, 32'h0);
    check32({nm, "_done"}, 32'({bus.o_done, bus.o_error}), 32'd0);
    @(negedge clk);
    check32({nm, "_ready_after"}, 32'(bus.o_ready), 32'd1);
    check32({nm, "_stall_after"}, 32'(bus.o_stall), 32'd0);
  endtask

  // Valid held high with a new legal request every cycle; timing expectations come from the bench.
  task automatic continuous_test();
    int last_acc, size;
    bit exp_ready, exp_done;
    logic [31:0] pd, a, d;
    logic pe, r;
    logic [2:0] c;
    last_acc = -1;
    pd = 32'h0; pe = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      exp_ready = (last_acc < 0) || (cyc - last_acc >= W + 2);
      exp_done  = (last_acc >= 0) && (cyc - last_acc == W + 1);
      check32("cont_ready", 32'(bus.o_ready), 32'(exp_ready));
      check32("cont_stall", 32'(bus.o_stall), 32'(!exp_ready));
      check32("cont_done", 32'(bus.o_done), 32'(exp_done));
      if (exp_done) begin
        check32("cont_data", bus.o_read_data, pd);
        check32("cont_err", 32'(bus.o_error), 32'(pe));
      end
      r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: c = 3'b000;
        1: c = 3'b001;
        default: c = 3'b011;
      endcase
      if (r && $urandom_range(0, 1) == 1) c[2] = 1'b1;
      if (c == 3'b100 && !r) c = 3'b000;
      size = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
      a = $urandom & ~32'(size - 1);
      d = $urandom;
      drive_req(r, !r, c, a, d);
      if (exp_ready) begin
        model_step(r, !r, c, a, d, pd, pe);
        last_acc = cyc;
      end
    end
    drive_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gd;
    logic ge, rr, ww;
    int sel;

    add_vec(1'b0, 1'b1, 3'b011, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, "sw_010");
    add_vec(1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, "lw_010");
    add_vec(1'b1, 1'b0, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, "lb_013");
    add_vec(1'b1, 1'b0, 3'b100, 32'h013, 32'h0,        32'h000000DE, 1'b0, "lbu_013");
    add_vec(1'b1, 1'b0, 3'b001, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_010");
    add_vec(1'b1, 1'b0, 3'b101, 32'h012, 32'h0,        32'h0000DEAD, 1'b0, "lhu_012");
    add_vec(1'b0, 1'b1, 3'b000, 32'h011, 32'hAAAAAA55, 32'h0000DEAD, 1'b0, "sb_011");
    add_vec(1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'hDEAD55EF, 1'b0, "lw_after_sb");
    add_vec(1'b0, 1'b1, 3'b011, 32'h012, 32'h0BADF00D, 32'h00000000, 1'b1, "sw_misaligned");
    add_vec(1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'hDEAD55EF, 1'b0, "lw_after_mis");
    add_vec(1'b1, 1'b0, 3'b001, 32'h011, 32'h0,        32'h00000000, 1'b1, "lh_misaligned");
    add_vec(1'b1, 1'b0, 3'b010, 32'h010, 32'h0,        32'h00000000, 1'b1, "illegal_010");
    add_vec(1'b1, 1'b1, 3'b011, 32'h010, 32'h11111111, 32'h00000000, 1'b1, "read_and_write");
    add_vec(1'b0, 1'b1, 3'b100, 32'h010, 32'h00000099, 32'h00000000, 1'b1, "sbu_store");
    add_vec(1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'hDEAD55EF, 1'b0, "lw_unchanged");
    add_vec(1'b0, 1'b1, 3'b001, 32'h012, 32'h1234CAFE, 32'hDEAD55EF, 1'b0, "sh_012");
    add_vec(1'b1, 1'b0, 3'b011, 32'hFFFFF410, 32'h0,   32'hCAFE55EF, 1'b0, "lw_wrap");
    add_vec(1'b1, 1'b0, 3'b000, 32'h011, 32'h0,        32'h00000055, 1'b0, "lb_positive");
    add_vec(1'b1, 1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFFCAFE, 1'b0, "lh_012");
    add_vec(1'b1, 1'b0, 3'b101, 32'h010, 32'h0,        32'h000055EF, 1'b0, "lhu_010");
    add_vec(1'b1, 1'b0, 3'b111, 32'h010, 32'h0,        32'hCAFE55EF, 1'b0, "lwu_010");

    drive_idle();
    rst_n  = 1'b0;
    hold_m = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_ready", 32'(bus.o_ready), 32'd1);
    check32("reset_stall", 32'(bus.o_stall), 32'd0);
    check32("reset_done", 32'(bus.o_done), 32'd0);
    check32("reset_error", 32'(bus.o_error), 32'd0);
    check32("reset_rdata", bus.o_read_data, 32'h0);
    rst_n = 1'b1;

    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b011, 32'h010, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check32("ignored_ready", 32'(bus.o_ready), 32'd1);
      check32("ignored_done_err", 32'({bus.o_done, bus.o_error}), 32'd0);
    end
    drive_idle();

    for (int w = 0; w < 256; w++) run_model_req(1'b0, 1'b1, 3'b011, 32'(w * 4), $urandom, "init");

    foreach (tbl[i]) begin
      logic [31:0] md;
      logic me;
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].code, tbl[i].addr, tbl[i].data, md, me);
      do_req(tbl[i].rd, tbl[i].wr, tbl[i].code, tbl[i].addr, tbl[i].data, gd, ge);
      check32({tbl[i].name, "_data"}, gd, tbl[i].exp_data);
      check32({tbl[i].name, "_err"}, 32'(ge), 32'(tbl[i].exp_err));
    end

    reset_during(1, "rst_access");
    run_model_req(1'b1, 1'b0, 3'b011, 32'h020, 32'h0, "lw_after_rst_access");
    reset_during(W, "rst_commit");
    run_model_req(1'b1, 1'b0, 3'b011, 32'h020, 32'h0, "lw_after_rst_commit");

    continuous_test();

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      rr  = (sel == 0) || (sel >= 1 && sel <= 5);
      ww  = (sel == 0) || (sel >= 6);
      run_model_req(rr, ww, 3'($urandom_range(0, 7)), $urandom, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
